// File: rtl/snr_power_meter_if.sv
// snr_power_meter_if: sample/result bundle between a sample source (master) and the SNR power meter (slave)
//   start     : begin a measurement window (master -> slave)
//   in_valid  : y/y_hat pair valid this cycle (master -> slave)
//   y, y_hat  : clean and noisy samples, two's-complement signed (master -> slave)
//   busy      : window in progress (slave -> master)
//   done      : one-cycle pulse when results update (slave -> master)
//   sig_pow   : mean of y^2 over the window, unsigned (slave -> master)
//   noise_pow : mean of (y_hat-y)^2 over the window, unsigned (slave -> master)
//   err_mean  : mean of (y_hat-y), signed, floor (slave -> master)
interface snr_power_meter_if #(
    parameter int DATA_W = 32
);
    logic                start;
    logic                in_valid;
    logic [DATA_W-1:0]   y;
    logic [DATA_W-1:0]   y_hat;
    logic                busy;
    logic                done;
    logic [2*DATA_W-1:0] sig_pow;
    logic [2*DATA_W-1:0] noise_pow;
    logic [DATA_W:0]     err_mean;
    modport master (
        output start, in_valid, y, y_hat,
        input  busy, done, sig_pow, noise_pow, err_mean
    );
    modport slave (
        input  start, in_valid, y, y_hat,
        output busy, done, sig_pow, noise_pow, err_mean
    );
endinterface

// File: rtl/snr_power_meter.sv
// snr_power_meter: averages y^2 and (y_hat-y)^2 over 2^WIN_LOG2 accepted samples and reports both means
//   clk   : single clock, rising edge
//   reset : synchronous active-high reset, overrides all other inputs
//   bus   : snr_power_meter_if slave (start, in_valid, y, y_hat in; busy, done, sig_pow, noise_pow, err_mean out)
//   Macro SNR_ERR_MEAN_EN builds the signed error-mean accumulator; otherwise err_mean is tied to 0.
module snr_power_meter #(
    parameter int DATA_W   = 32,
    parameter int WIN_LOG2 = 10
) (
    input  logic             clk,
    input  logic             reset,
    snr_power_meter_if.slave bus
);
    localparam int ACC_W = 2*DATA_W + WIN_LOG2;
    localparam logic [WIN_LOG2:0] LAST = {1'b0, {WIN_LOG2{1'b1}}};
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t              r_state;
    logic [WIN_LOG2:0]   r_cnt;
    logic [ACC_W-1:0]    r_acc_sig;
    logic [ACC_W-1:0]    r_acc_noise;
    logic                r_busy;
    logic                r_done;
    logic [2*DATA_W-1:0] r_sig_pow;
    logic [2*DATA_W-1:0] r_noise_pow;
    logic signed [DATA_W:0] w_e;
    logic [DATA_W-1:0]   w_y_mag;
    logic [DATA_W-1:0]   w_e_mag;
    logic [2*DATA_W-1:0] w_y_sq;
    logic [2*DATA_W-1:0] w_e_sq;
    logic [ACC_W-1:0]    w_sig_next;
    logic [ACC_W-1:0]    w_noise_next;
    logic                w_accept;
    logic                w_last;
    // Squares are formed from magnitudes so an unsigned 2*DATA_W product holds
    // even the (-2^(DATA_W-1))^2 and (2^DATA_W-1)^2 extremes.
    assign w_e          = {bus.y_hat[DATA_W-1], bus.y_hat} - {bus.y[DATA_W-1], bus.y};
    assign w_y_mag      = bus.y[DATA_W-1] ? -bus.y : bus.y;
    assign w_e_mag      = w_e[DATA_W] ? DATA_W'(-w_e) : DATA_W'(w_e);
    assign w_y_sq       = (2*DATA_W)'(w_y_mag) * (2*DATA_W)'(w_y_mag);
    assign w_e_sq       = (2*DATA_W)'(w_e_mag) * (2*DATA_W)'(w_e_mag);
    assign w_sig_next   = r_acc_sig + ACC_W'(w_y_sq);
    assign w_noise_next = r_acc_noise + ACC_W'(w_e_sq);
    assign w_accept     = (r_state == RUN) && bus.in_valid;
    assign w_last       = r_cnt == LAST;
`ifdef SNR_ERR_MEAN_EN
    localparam int ERR_W = DATA_W + 1 + WIN_LOG2;
    logic signed [ERR_W-1:0] r_acc_err;
    logic signed [ERR_W-1:0] w_err_next;
    logic [DATA_W:0]         r_err_mean;
    assign w_err_next   = r_acc_err + ERR_W'(w_e);
    assign bus.err_mean = r_err_mean;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_err  <= '0;
            r_err_mean <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_acc_err  <= '0;
        end else if (w_accept) begin
            r_acc_err  <= w_err_next;
            // Dropping the low WIN_LOG2 bits of a signed sum is an arithmetic shift (floor).
            if (w_last) r_err_mean <= w_err_next[ERR_W-1:WIN_LOG2];
        end
    end
`else
    assign bus.err_mean = '0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc_sig   <= '0;
            r_acc_noise <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sig_pow   <= '0;
            r_noise_pow <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state     <= RUN;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_acc_sig   <= '0;
                        r_acc_noise <= '0;
                    end
                end
                RUN: begin
                    if (bus.in_valid) begin
                        r_cnt       <= r_cnt + 1'b1;
                        r_acc_sig   <= w_sig_next;
                        r_acc_noise <= w_noise_next;
                        // The final sample's contribution is folded in directly so the
                        // means are valid in the same cycle done is high.
                        if (w_last) begin
                            r_state     <= DONE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_sig_pow   <= w_sig_next[ACC_W-1:WIN_LOG2];
                            r_noise_pow <= w_noise_next[ACC_W-1:WIN_LOG2];
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.sig_pow   = r_sig_pow;
    assign bus.noise_pow = r_noise_pow;
endmodule
